// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU fetch/issue controller: opcodes, FSM states,
// instruction field positions and the HALT encoding.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_BEQ = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam int IR_OP_HI  = 15;
    localparam int IR_OP_LO  = 13;
    localparam int IR_RD_HI  = 12;
    localparam int IR_RD_LO  = 11;
    localparam int IR_RA_HI  = 10;
    localparam int IR_RA_LO  = 9;
    localparam int IR_RB_HI  = 8;
    localparam int IR_RB_LO  = 7;
    localparam int IR_IMM_HI = 5;
    localparam int IR_IMM_LO = 0;

    localparam logic [5:0] HALT_IMM = 6'h3F;

    localparam int NUM_REGS  = 4;
    localparam int REG_SEL_W = 2;

endpackage

// File: rtl/ctrl_regfile.sv
// 4-entry register file: two operand read ports, a debug read port and a
// single write port whose source is selected by the controller.
module ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_SEL_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_SEL_W-1:0] ra_sel,
    output logic [DATA_W-1:0]    ra_data,
    input  logic [REG_SEL_W-1:0] rb_sel,
    output logic [DATA_W-1:0]    rb_data,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data  = regs_q[ra_sel];
    assign rb_data  = regs_q[rb_sel];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Fetch/issue controller driving an 8-bit registered ALU: fetches instructions,
// issues operands, captures results one cycle later and resolves BEQ branches.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 6,
    parameter int IW     = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [IW-1:0]     imem_data,
    input  logic              imem_valid,
    output logic [2:0]        alu_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [PC_W-1:0]   alu_branch_addr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_co,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_sel,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              carry_flag,
    output logic              eq_flag,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              eq_q, eq_d;

    logic [2:0]        f_op;
    logic [5:0]        f_imm;
    logic [2:0]        ir_op;
    logic [1:0]        ir_rd, ir_ra, ir_rb;
    logic [PC_W-1:0]   pc_inc;
    logic              unused_ir6;

    logic              rf_we;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] ra_data, rb_data;

    assign f_op   = imem_data[IR_OP_HI:IR_OP_LO];
    assign f_imm  = imem_data[IR_IMM_HI:IR_IMM_LO];
    assign ir_op  = ir_q[IR_OP_HI:IR_OP_LO];
    assign ir_rd  = ir_q[IR_RD_HI:IR_RD_LO];
    assign ir_ra  = ir_q[IR_RA_HI:IR_RA_LO];
    assign ir_rb  = ir_q[IR_RB_HI:IR_RB_LO];
    assign pc_inc = pc_q + PC_W'(1);
    assign unused_ir6 = ir_q[6];

    ctrl_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (CLK),
        .rst_n    (RST_N),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_sel   (ir_ra),
        .ra_data  (ra_data),
        .rb_sel   (ir_rb),
        .rb_data  (rb_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_rdata)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        eq_d     = eq_q;
        rf_we    = 1'b0;
        rf_waddr = dbg_sel;
        rf_wdata = dbg_wdata;

        case (state_q)
            IDLE: begin
                rf_we = dbg_we;
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_d = imem_data;
                    case (f_op)
                        OP_NOP: begin
                            // HALT leaves PC on itself so a later run re-fetches it
                            if (f_imm == HALT_IMM) begin
                                state_d = IDLE;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_BEQ: begin
                            pc_d = eq_q ? PC_W'(f_imm) : pc_inc;
                            eq_d = 1'b0;
                        end
                        default: state_d = ISSUE;
                    endcase
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                pc_d    = pc_inc;
                state_d = FETCH;
                rf_waddr = ir_rd;
                rf_wdata = alu_out;
                case (ir_op)
                    OP_ADD, OP_SUB: begin
                        rf_we   = 1'b1;
                        carry_d = alu_co;
                    end
                    OP_AND, OP_NOT, OP_OR: begin
                        rf_we   = 1'b1;
                        carry_d = 1'b0;
                    end
                    OP_CMP: begin
                        eq_d = alu_out[0];
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
        end
    end

    // ALU drive is qualified by ISSUE so the ALU sees NOP/zero operands otherwise
    assign alu_instr       = (state_q == ISSUE) ? ir_op   : OP_NOP;
    assign alu_a           = (state_q == ISSUE) ? ra_data : '0;
    assign alu_b           = (state_q == ISSUE) ? rb_data : '0;
    assign alu_branch_addr = PC_W'(ir_q[IR_IMM_HI:IR_IMM_LO]);
    assign imem_req        = (state_q == FETCH);
    assign imem_addr       = pc_q;
    assign carry_flag      = carry_q;
    assign eq_flag         = eq_q;
    assign halted          = (state_q == IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural instruction memory and
// a registered 8-bit ALU model on the driven side.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    localparam int DATA_W = 8;
    localparam int PC_W   = 6;
    localparam int IW     = 16;

    logic              CLK;
    logic              RST_N;
    logic              run;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [IW-1:0]     imem_data;
    logic              imem_valid;
    logic [2:0]        alu_instr;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [PC_W-1:0]   alu_branch_addr;
    logic [DATA_W-1:0] alu_out;
    logic              alu_co;
    logic              dbg_we;
    logic [1:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              carry_flag, eq_flag, halted;

    logic [IW-1:0]     mem [64];
    logic              vld_en;

    int n_chk;
    int n_pass;

    alu_issue_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .IW(IW)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .run             (run),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .imem_valid      (imem_valid),
        .alu_instr       (alu_instr),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_branch_addr (alu_branch_addr),
        .alu_out         (alu_out),
        .alu_co          (alu_co),
        .dbg_we          (dbg_we),
        .dbg_sel         (dbg_sel),
        .dbg_wdata       (dbg_wdata),
        .dbg_rdata       (dbg_rdata),
        .carry_flag      (carry_flag),
        .eq_flag         (eq_flag),
        .halted          (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign imem_data  = mem[imem_addr];
    assign imem_valid = vld_en;

    // Registered ALU; carry for logic ops is driven high so forcing it to 0 is visible
    always_ff @(posedge CLK) begin
        case (alu_instr)
            OP_ADD: {alu_co, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: {alu_co, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: {alu_co, alu_out} <= {1'b1, alu_a & alu_b};
            OP_NOT: {alu_co, alu_out} <= {1'b1, ~alu_a};
            OP_OR:  {alu_co, alu_out} <= {1'b1, alu_a | alu_b};
            OP_CMP: {alu_co, alu_out} <= {1'b0, 7'd0, (alu_a == alu_b)};
            default: {alu_co, alu_out} <= 9'd0;
        endcase
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb,
                                        input logic [5:0] imm);
        return {op, rd, ra, rb, 1'b0, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = enc(OP_NOP, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic dbg_write(input logic [1:0] sel, input logic [7:0] data);
        dbg_we = 1'b1; dbg_sel = sel; dbg_wdata = data;
        @(negedge CLK);
        dbg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [7:0] data);
        dbg_sel = sel;
        #1;
        data = dbg_rdata;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget, input logic [2:0] watch_op,
                             output int n_op, output logic [7:0] a_seen);
        logic done;
        done = 1'b0;
        n_op = 0;
        a_seen = 8'hXX;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            if (alu_instr == watch_op) begin
                n_op++;
                a_seen = alu_a;
            end
            if (halted) done = 1'b1;
        end
        check({tag, "_halt_reached"}, done, 1'b1);
    endtask

    task automatic wait_addr(input string tag, input int budget, input logic [5:0] addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (imem_req && imem_addr == addr) found = 1'b1;
        end
        check({tag, "_addr_reached"}, found, 1'b1);
    endtask

    initial begin
        logic [7:0] rv;
        logic [7:0] a_seen;
        int         n_op;
        logic       found;

        n_chk = 0; n_pass = 0;
        RST_N = 1'b0; run = 1'b0; dbg_we = 1'b0; dbg_sel = 2'd0; dbg_wdata = '0;
        vld_en = 1'b1;
        clear_mem();

        // ADD with carry-out, then HALT
        do_reset();
        check("rst_halted", halted, 1'b1);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_alu_instr", alu_instr, 3'b000);
        check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        check("rst_flags", {carry_flag, eq_flag}, 2'b00);
        check("rst_pc", imem_addr, 6'd0);
        read_reg(2'd3, rv);
        check("rst_r3", rv, 8'h00);
        dbg_write(2'd1, 8'hF0);
        dbg_write(2'd2, 8'h20);
        mem[0] = enc(OP_ADD, 2'd3, 2'd1, 2'd2, 6'd0);
        mem[1] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        pulse_run();
        wait_halt("add", 40, OP_ADD, n_op, a_seen);
        check("add_issue_cycles", n_op, 1);
        read_reg(2'd3, rv);
        check("add_r3", rv, 8'h10);
        check("add_carry", carry_flag, 1'b1);
        check("add_halt_pc", imem_addr, 6'd1);

        // CMP equal, BEQ taken
        clear_mem();
        do_reset();
        dbg_write(2'd1, 8'h05);
        dbg_write(2'd2, 8'h05);
        mem[0]    = enc(OP_CMP, 2'd3, 2'd1, 2'd2, 6'd0);
        mem[1]    = enc(OP_BEQ, 2'd0, 2'd0, 2'd0, 6'h20);
        mem[6'h20] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        pulse_run();
        wait_addr("beq_t_cmp", 20, 6'd1);
        check("beq_t_eq_after_cmp", eq_flag, 1'b1);
        wait_addr("beq_t_target", 20, 6'h20);
        check("beq_t_eq_cleared", eq_flag, 1'b0);
        wait_halt("beq_t", 20, OP_CMP, n_op, a_seen);
        check("beq_t_halt_pc", imem_addr, 6'h20);
        read_reg(2'd3, rv);
        check("cmp_no_write", rv, 8'h00);

        // CMP unequal, BEQ not taken
        clear_mem();
        do_reset();
        dbg_write(2'd1, 8'h05);
        dbg_write(2'd2, 8'h06);
        mem[0] = enc(OP_CMP, 2'd0, 2'd1, 2'd2, 6'd0);
        mem[1] = enc(OP_BEQ, 2'd0, 2'd0, 2'd0, 6'h20);
        mem[2] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        pulse_run();
        wait_addr("beq_n_cmp", 20, 6'd1);
        check("beq_n_eq_after_cmp", eq_flag, 1'b0);
        wait_halt("beq_n", 20, OP_CMP, n_op, a_seen);
        check("beq_n_halt_pc", imem_addr, 6'd2);

        // NOT R0,R0 reads the old value; logic op clears a prior carry
        clear_mem();
        do_reset();
        dbg_write(2'd0, 8'h0F);
        dbg_write(2'd1, 8'hF0);
        dbg_write(2'd2, 8'h20);
        mem[0] = enc(OP_ADD, 2'd3, 2'd1, 2'd2, 6'd0);
        mem[1] = enc(OP_NOT, 2'd0, 2'd0, 2'd0, 6'd0);
        mem[2] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        pulse_run();
        wait_addr("not_pre", 20, 6'd1);
        check("not_pre_carry", carry_flag, 1'b1);
        wait_halt("not", 20, OP_NOT, n_op, a_seen);
        check("not_issue_a", a_seen, 8'h0F);
        read_reg(2'd0, rv);
        check("not_r0", rv, 8'hF0);
        check("not_carry", carry_flag, 1'b0);

        // PC wrap at 63 and an indefinite imem wait
        clear_mem();
        do_reset();
        mem[0]  = enc(OP_CMP, 2'd0, 2'd0, 2'd0, 6'd0);
        mem[1]  = enc(OP_BEQ, 2'd0, 2'd0, 2'd0, 6'd63);
        pulse_run();
        wait_addr("wrap_63", 20, 6'd63);
        wait_addr("wrap_0", 5, 6'd0);
        vld_en = 1'b0;
        mem[0] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        dbg_we = 1'b1; dbg_sel = 2'd2; dbg_wdata = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            dbg_we = 1'b0;
            check("stall_req", imem_req, 1'b1);
            check("stall_addr", imem_addr, 6'd0);
        end
        vld_en = 1'b1;
        wait_halt("wrap", 10, OP_NOP, n_op, a_seen);
        check("wrap_halt_pc", imem_addr, 6'd0);
        read_reg(2'd2, rv);
        check("dbg_we_ignored", rv, 8'h00);

        // Async reset during CAPTURE of an ADD
        clear_mem();
        do_reset();
        dbg_write(2'd1, 8'hF0);
        dbg_write(2'd2, 8'h20);
        mem[0] = enc(OP_ADD, 2'd3, 2'd1, 2'd2, 6'd0);
        mem[1] = enc(OP_NOP, 2'd0, 2'd0, 2'd0, HALT_IMM);
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (alu_instr == OP_ADD) found = 1'b1;
        end
        check("arst_issue_seen", found, 1'b1);
        @(posedge CLK);
        #2;
        check("arst_pre_running", halted, 1'b0);
        RST_N = 1'b0;
        #1;
        check("arst_halted", halted, 1'b1);
        check("arst_imem_req", imem_req, 1'b0);
        check("arst_alu", {alu_instr, alu_a, alu_b}, 19'd0);
        check("arst_flags", {carry_flag, eq_flag}, 2'b00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        read_reg(2'd3, rv);
        check("arst_r3", rv, 8'h00);
        check("arst_stays_idle", halted, 1'b1);
        check("arst_carry", carry_flag, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
